axi2mem_rd_channel_mb: RTL and testbench
========================================

# axi2mem_rd_channel_mb

Parametrised read channel that converts AXI4 AR bursts into per-lane 32-bit memory command requests, and returns memory read data as AXI4 R beats. The bus is split into NB_LANES = AXI_DATA_WIDTH/32 lanes. It supports FIXED, INCR and WRAP bursts and narrow transfer sizes. The block sits between the AXI slave port and the TCDM command/data queues, as the read half of axi2mem.

## Interface
- AXI_ADDR_WIDTH, 32, AR address width
- AXI_DATA_WIDTH, 64, R data width; legal values 32/64/128/256
- AXI_ID_WIDTH, 3, AXI ID width
- AXI_USER_WIDTH, 6, AXI user width
- TRANS_ID_WIDTH, 6, command ID width; must be ≥ AXI_ID_WIDTH
- ID_FIFO_DEPTH, 4, number of outstanding bursts (power of 2)
- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  reset; synchronous, active-low
- axi_slave_ar_valid_i/ready_o  in/out  1  AR handshake
- axi_slave_ar_addr_i  in  AXI_ADDR_WIDTH  burst start address
- axi_slave_ar_len_i  in  8  beats−1
- axi_slave_ar_size_i  in  3  log2 bytes per beat; must be ≤ log2(AXI_DATA_WIDTH/8)
- axi_slave_ar_burst_i  in  2  burst type: 00 FIXED, 01 INCR, 10 WRAP
- axi_slave_ar_id_i  in  AXI_ID_WIDTH  transaction ID
- axi_slave_ar_prot/region/lock/cache/qos/user_i  in  std  accepted and ignored
- axi_slave_r_valid_o/ready_i  out/in  1  R handshake
- axi_slave_r_data_o  out  AXI_DATA_WIDTH  read data
- axi_slave_r_resp_o  out  2  response
- axi_slave_r_last_o  out  1  last beat of burst
- axi_slave_r_id_o  out  AXI_ID_WIDTH  response ID
- axi_slave_r_user_o  out  AXI_USER_WIDTH  constant 0
- trans_req_o / trans_gnt_i  out/in  NB_LANES  per-lane command handshake
- trans_add_o  out  NB_LANES×32  per-lane word address
- trans_id_o  out  NB_LANES×TRANS_ID_WIDTH  latched AR ID, zero-extended
- trans_last_o  out  NB_LANES  marks the final beat of the burst
- data_dat_i  in  AXI_DATA_WIDTH  memory read data
- data_last_i  in  1  last flag from the data queue
- data_gnt_i / data_req_o  in/out  1  data queue has data / pop the data queue

## Operation
- FSM states:
  - IDLE
    - Accept AR when ar_valid & &trans_gnt_i & ID FIFO not full.
    - On accept: drive beat 0 to the lanes, push ID into the ID FIFO, latch addr/len/size/burst/id.
    - len==0 → trans_last on all lanes and stay in IDLE; otherwise go to RUN with beat count = 1.
  - RUN
    - ar_ready=0.
    - When &trans_gnt_i: issue beat[count] on all lanes, count++.
    - Beat with count==len sets trans_last and returns the FSM to IDLE.
- trans_req is all-or-nothing: all lanes request only when all grants are high.
- Beat address:
  - A_n is computed, then aligned down to DATA_BYTES.
  - Lane i address = aligned A_n + 4·i.
  - FIXED: A_n = start.
  - INCR: A_n = start_aligned_to_size + n·2^size; 12-bit carry allowed (no 4 KB check).
  - WRAP: wrap_bytes = (len+1)·2^size, base = start & ~(wrap_bytes−1), A_n = base + ((start + n·2^size) mod wrap_bytes).
  - WRAP with len ∉ {1,3,7,15} is treated as INCR.
  - Reserved burst 11 is treated as INCR, and every R beat of that burst returns SLVERR (10). A resp-flag bit is stored alongside the ID in the FIFO.
- trans_id carries the latched ID in both IDLE-accept and RUN (never the live ar_id).
- Response path:
  - r_valid = data_gnt_i & id_fifo_valid.
  - data_req_o = r_valid & r_ready.
  - r_last = data_last_i, r_data = data_dat_i.
  - r_id and r_resp come from the FIFO head; the head is popped on handshake & data_last_i.
  - r_valid never depends on r_ready.
- Simultaneous ID FIFO push and pop are allowed when full; the pop frees the slot in the same cycle.

## Timing
- Reset (rst_ni low at a clock edge):
  - FSM → IDLE, beat count 0, ID FIFO emptied.
  - All outputs driven low while in reset and the cycle after: ar_ready, trans_req, trans_last, r_valid, r_last, data_req = 0; trans_add/trans_id = 0; r_resp = 00.
- Reset mid-burst aborts the burst with no further trans_req; in-flight memory data is the system's responsibility.
- AR→first command: 0 cycles (combinational with accept).
- Throughput: one beat per cycle with grants held high, so a burst of len+1 beats takes len+1 cycles of issue.
- Next AR can be accepted in the cycle after the last-beat issue.
- data_gnt→r_valid: combinational, 0 cycles. Data beats retire at one per cycle.

## Structure
- Package axi2mem_rd_pkg:
  - burst enum: FIXED, INCR, WRAP, RSVD.
  - resp constants: OKAY=00, SLVERR=10.
  - FSM state enum.
  - function lanes(AXI_DATA_WIDTH).
- ID FIFO: instance of the existing axi2mem_buffer, DATA_WIDTH = AXI_ID_WIDTH+1, depth ID_FIFO_DEPTH.
- Sub-module axi2mem_burst_addr_gen: combinational beat-address computation from (start, len, size, burst, count).

## Test plan
- **Single beat:** 64-bit bus, AR addr 0x1004, len 0, INCR, grants high → same cycle lane0=0x1000, lane1=0x1004, trans_last=11, ar_ready=1; FSM remains IDLE.
- **INCR burst:** addr 0x100, len 3, size 3 → lane0 addresses 0x100, 0x108, 0x110, 0x118 on consecutive cycles; last on the 4th beat; stall trans_gnt for 2 cycles mid-burst → addresses held, no skipped beat.
- **WRAP burst:** addr 0x118, len 3, size 3 → lane0 addresses 0x118, 0x100, 0x108, 0x110. FIXED burst, len 2 → 0x40 three times.
- **Narrow INCR:** size 2, addr 0x0, len 3, 64-bit bus → aligned beat addresses 0x0, 0x0, 0x8, 0x8.
- **Outstanding IDs:** 5 ARs with IDs 1..5 and no data returned → 5th AR stalls (ar_ready=0) until the first last-beat R handshake. R IDs come out in order 1..5. Holding r_ready=0 keeps r_valid=1 and data_req=0.
- **Error and reset:** burst=11, len 1 → two beats with r_resp=10. rst_ni asserted during beat 2 of a len-7 burst → next cycle trans_req=0, FIFO empty, r_valid=0.

Source files
------------

// File: rtl/axi2mem_rd_pkg.sv
// Shared types and constants for the axi2mem read channel.
package axi2mem_rd_pkg;

   // AXI burst encodings; RSVD is handled as INCR with an error response
   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10,
      BURST_RSVD  = 2'b11
   } burst_e;

   // AXI response codes used by this channel
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Command-issue FSM states
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01
   } rd_state_e;

   // Number of 32-bit memory lanes on a bus of the given width
   function automatic int lanes(input int data_width);
      return data_width / 32;
   endfunction

endpackage

// File: rtl/axi2mem_buffer.sv
// Small synchronous FIFO. A pop in the same cycle frees the slot for a
// simultaneous push, so ready_o stays high when full and being drained.
module axi2mem_buffer #(
   parameter int DATA_WIDTH   = 4,
   parameter int BUFFER_DEPTH = 4
)(
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  valid_o,
   input  logic                  ready_i
);

   localparam int PW = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
   localparam logic [PW:0] FULL_CNT = (PW+1)'(BUFFER_DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [BUFFER_DEPTH];
   logic [PW-1:0]         wr_ptr_q;
   logic [PW-1:0]         rd_ptr_q;
   logic [PW:0]           cnt_q;
   logic                  push;
   logic                  pop;

   assign valid_o = (cnt_q != '0);
   assign ready_o = (cnt_q != FULL_CNT) | ready_i;
   assign push    = valid_i & ready_o;
   assign pop     = valid_o & ready_i;
   assign data_o  = mem_q[rd_ptr_q];

   // Pointer and occupancy bookkeeping
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage write; contents need no reset because occupancy gates them
   always_ff @(posedge clk_i) begin
      if (push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/axi2mem_burst_addr_gen.sv
// Combinational AXI beat address for beat index count_i of a burst,
// aligned down to the full bus width.
module axi2mem_burst_addr_gen
   import axi2mem_rd_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_BYTES = 8
)(
   input  logic [ADDR_WIDTH-1:0] start_i,
   input  logic [7:0]            len_i,
   input  logic [2:0]            size_i,
   input  logic [1:0]            burst_i,
   input  logic [7:0]            count_i,
   output logic [ADDR_WIDTH-1:0] addr_o
);

   logic [ADDR_WIDTH-1:0] step;
   logic [ADDR_WIDTH-1:0] size_mask;
   logic [ADDR_WIDTH-1:0] wrap_bytes;
   logic [ADDR_WIDTH-1:0] wrap_mask;
   logic [ADDR_WIDTH-1:0] incr_addr;
   logic [ADDR_WIDTH-1:0] wrap_addr;
   logic [ADDR_WIDTH-1:0] beat_addr;
   logic                  wrap_legal;

   // Compute FIXED/INCR/WRAP candidates and select by burst type
   always_comb begin
      step       = ADDR_WIDTH'(count_i) << size_i;
      size_mask  = (ADDR_WIDTH'(1) << size_i) - ADDR_WIDTH'(1);
      wrap_bytes = (ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i;
      wrap_mask  = wrap_bytes - ADDR_WIDTH'(1);
      incr_addr  = (start_i & ~size_mask) + step;
      wrap_addr  = (start_i & ~wrap_mask) + ((start_i + step) & wrap_mask);
      wrap_legal = (len_i == 8'd1) || (len_i == 8'd3) ||
                   (len_i == 8'd7) || (len_i == 8'd15);
      case (burst_e'(burst_i))
         BURST_FIXED: beat_addr = start_i;
         BURST_WRAP:  beat_addr = wrap_legal ? wrap_addr : incr_addr;
         default:     beat_addr = incr_addr;
      endcase
      addr_o = beat_addr & ~ADDR_WIDTH'(DATA_BYTES - 1);
   end

endmodule

// File: rtl/axi2mem_rd_channel_mb.sv
// AXI4 read channel: splits AR bursts into per-lane 32-bit memory commands
// and returns memory read data as R beats, with IDs kept in order by a FIFO.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high. valid never waits for ready; ready may depend on valid's partner
// conditions but a producer holds its payload stable until the transfer.
// The lane command port is all-or-nothing: every lane requests together and
// only in a cycle where every lane grant is high.
module axi2mem_rd_channel_mb
   import axi2mem_rd_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int AXI_ID_WIDTH   = 3,
   parameter int AXI_USER_WIDTH = 6,
   parameter int TRANS_ID_WIDTH = 6,
   parameter int ID_FIFO_DEPTH  = 4,
   localparam int NB_LANES      = lanes(AXI_DATA_WIDTH)
)(
   input  logic                               clk_i,
   input  logic                               rst_ni,

   input  logic                               axi_slave_ar_valid_i,
   output logic                               axi_slave_ar_ready_o,
   input  logic [AXI_ADDR_WIDTH-1:0]          axi_slave_ar_addr_i,
   input  logic [7:0]                         axi_slave_ar_len_i,
   input  logic [2:0]                         axi_slave_ar_size_i,
   input  logic [1:0]                         axi_slave_ar_burst_i,
   input  logic [AXI_ID_WIDTH-1:0]            axi_slave_ar_id_i,
   input  logic [2:0]                         axi_slave_ar_prot_i,
   input  logic [3:0]                         axi_slave_ar_region_i,
   input  logic                               axi_slave_ar_lock_i,
   input  logic [3:0]                         axi_slave_ar_cache_i,
   input  logic [3:0]                         axi_slave_ar_qos_i,
   input  logic [AXI_USER_WIDTH-1:0]          axi_slave_ar_user_i,

   output logic                               axi_slave_r_valid_o,
   input  logic                               axi_slave_r_ready_i,
   output logic [AXI_DATA_WIDTH-1:0]          axi_slave_r_data_o,
   output logic [1:0]                         axi_slave_r_resp_o,
   output logic                               axi_slave_r_last_o,
   output logic [AXI_ID_WIDTH-1:0]            axi_slave_r_id_o,
   output logic [AXI_USER_WIDTH-1:0]          axi_slave_r_user_o,

   output logic [NB_LANES-1:0]                trans_req_o,
   input  logic [NB_LANES-1:0]                trans_gnt_i,
   output logic [NB_LANES*32-1:0]             trans_add_o,
   output logic [NB_LANES*TRANS_ID_WIDTH-1:0] trans_id_o,
   output logic [NB_LANES-1:0]                trans_last_o,

   input  logic [AXI_DATA_WIDTH-1:0]          data_dat_i,
   input  logic                               data_last_i,
   input  logic                               data_gnt_i,
   output logic                               data_req_o,

   output logic [1:0]                         dbg_state_o
);

   localparam int DATA_BYTES = AXI_DATA_WIDTH / 8;

   rd_state_e                state_q, state_d;
   logic [7:0]               count_q, count_d;
   logic [AXI_ADDR_WIDTH-1:0] addr_q;
   logic [7:0]               len_q;
   logic [2:0]               size_q;
   logic [1:0]               burst_q;
   logic [AXI_ID_WIDTH-1:0]  id_q;
   logic                     out_en_q;
   logic                     out_en;

   logic                     all_gnt;
   logic                     ar_ready;
   logic                     accept;
   logic                     issue;
   logic                     last_beat;

   logic [AXI_ADDR_WIDTH-1:0] gen_start;
   logic [7:0]               gen_len;
   logic [2:0]               gen_size;
   logic [1:0]               gen_burst;
   logic [7:0]               gen_count;
   logic [AXI_ADDR_WIDTH-1:0] gen_addr;

   logic                     fifo_ready;
   logic                     fifo_valid;
   logic                     fifo_pop;
   logic [AXI_ID_WIDTH:0]    fifo_push_data;
   logic [AXI_ID_WIDTH:0]    fifo_head;
   logic                     r_valid;

   logic                     unused_inputs;

   // Outputs stay quiet during reset and for the first cycle after it
   assign out_en  = rst_ni & out_en_q;
   assign all_gnt = &trans_gnt_i;

   // Next-state, command issue and address-generator input selection
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      ar_ready  = 1'b0;
      accept    = 1'b0;
      issue     = 1'b0;
      last_beat = 1'b0;
      gen_start = addr_q;
      gen_len   = len_q;
      gen_size  = size_q;
      gen_burst = burst_q;
      gen_count = count_q;
      case (state_q)
         ST_IDLE: begin
            // Beat 0 goes out in the accept cycle, so use the live AR fields
            gen_start = axi_slave_ar_addr_i;
            gen_len   = axi_slave_ar_len_i;
            gen_size  = axi_slave_ar_size_i;
            gen_burst = axi_slave_ar_burst_i;
            gen_count = 8'd0;
            ar_ready  = out_en & all_gnt & fifo_ready;
            accept    = ar_ready & axi_slave_ar_valid_i;
            issue     = accept;
            last_beat = accept & (axi_slave_ar_len_i == 8'd0);
            if (accept && (axi_slave_ar_len_i != 8'd0)) begin
               state_d = ST_RUN;
               count_d = 8'd1;
            end
         end
         ST_RUN: begin
            issue     = out_en & all_gnt;
            last_beat = issue & (count_q == len_q);
            if (issue) begin
               if (count_q == len_q) begin
                  state_d = ST_IDLE;
                  count_d = 8'd0;
               end else begin
                  count_d = count_q + 8'd1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = 8'd0;
         end
      endcase
   end

   // FSM state, beat counter and output-enable register
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         count_q  <= 8'd0;
         out_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         out_en_q <= 1'b1;
      end
   end

   // Capture the burst descriptor on AR accept
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         addr_q  <= '0;
         len_q   <= 8'd0;
         size_q  <= 3'd0;
         burst_q <= 2'b00;
         id_q    <= '0;
      end else if (accept) begin
         addr_q  <= axi_slave_ar_addr_i;
         len_q   <= axi_slave_ar_len_i;
         size_q  <= axi_slave_ar_size_i;
         burst_q <= axi_slave_ar_burst_i;
         id_q    <= axi_slave_ar_id_i;
      end
   end

   axi2mem_burst_addr_gen #(
      .ADDR_WIDTH (AXI_ADDR_WIDTH),
      .DATA_BYTES (DATA_BYTES)
   ) i_addr_gen (
      .start_i (gen_start),
      .len_i   (gen_len),
      .size_i  (gen_size),
      .burst_i (gen_burst),
      .count_i (gen_count),
      .addr_o  (gen_addr)
   );

   assign trans_req_o  = {NB_LANES{issue}};
   assign trans_last_o = {NB_LANES{last_beat}};

   for (genvar i = 0; i < NB_LANES; i++) begin : g_lane
      assign trans_add_o[i*32 +: 32] = out_en ? (32'(gen_addr) + 32'(4 * i)) : 32'd0;
      assign trans_id_o[i*TRANS_ID_WIDTH +: TRANS_ID_WIDTH] =
         out_en ? TRANS_ID_WIDTH'(id_q) : '0;
   end

   // ID FIFO entry: {slave-error flag, AXI ID}
   assign fifo_push_data = {(axi_slave_ar_burst_i == BURST_RSVD), axi_slave_ar_id_i};

   axi2mem_buffer #(
      .DATA_WIDTH   (AXI_ID_WIDTH + 1),
      .BUFFER_DEPTH (ID_FIFO_DEPTH)
   ) i_id_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .data_i  (fifo_push_data),
      .valid_i (accept),
      .ready_o (fifo_ready),
      .data_o  (fifo_head),
      .valid_o (fifo_valid),
      .ready_i (fifo_pop)
   );

   // Response path: data beats pass straight through, ID/resp from FIFO head
   assign r_valid             = out_en & data_gnt_i & fifo_valid;
   assign data_req_o          = r_valid & axi_slave_r_ready_i;
   assign fifo_pop            = data_req_o & data_last_i;
   assign axi_slave_r_valid_o = r_valid;
   assign axi_slave_r_data_o  = data_dat_i;
   assign axi_slave_r_last_o  = out_en & data_last_i;
   assign axi_slave_r_id_o    = out_en ? fifo_head[AXI_ID_WIDTH-1:0] : '0;
   assign axi_slave_r_resp_o  = (out_en & fifo_head[AXI_ID_WIDTH]) ? RESP_SLVERR : RESP_OKAY;
   assign axi_slave_r_user_o  = '0;
   assign axi_slave_ar_ready_o = ar_ready;
   assign dbg_state_o         = state_q;

   assign unused_inputs = ^{axi_slave_ar_prot_i, axi_slave_ar_region_i, axi_slave_ar_lock_i,
                            axi_slave_ar_cache_i, axi_slave_ar_qos_i, axi_slave_ar_user_i};

endmodule

// File: tb/tb_axi2mem_rd_channel_mb.sv
// Directed bench for axi2mem_rd_channel_mb on a 64-bit (two-lane) bus.
module tb_axi2mem_rd_channel_mb;
   import axi2mem_rd_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        axi_slave_ar_valid_i;
   logic        axi_slave_ar_ready_o;
   logic [31:0] axi_slave_ar_addr_i;
   logic [7:0]  axi_slave_ar_len_i;
   logic [2:0]  axi_slave_ar_size_i;
   logic [1:0]  axi_slave_ar_burst_i;
   logic [2:0]  axi_slave_ar_id_i;
   logic [2:0]  axi_slave_ar_prot_i;
   logic [3:0]  axi_slave_ar_region_i;
   logic        axi_slave_ar_lock_i;
   logic [3:0]  axi_slave_ar_cache_i;
   logic [3:0]  axi_slave_ar_qos_i;
   logic [5:0]  axi_slave_ar_user_i;
   logic        axi_slave_r_valid_o;
   logic        axi_slave_r_ready_i;
   logic [63:0] axi_slave_r_data_o;
   logic [1:0]  axi_slave_r_resp_o;
   logic        axi_slave_r_last_o;
   logic [2:0]  axi_slave_r_id_o;
   logic [5:0]  axi_slave_r_user_o;
   logic [1:0]  trans_req_o;
   logic [1:0]  trans_gnt_i;
   logic [63:0] trans_add_o;
   logic [11:0] trans_id_o;
   logic [1:0]  trans_last_o;
   logic [63:0] data_dat_i;
   logic        data_last_i;
   logic        data_gnt_i;
   logic        data_req_o;
   logic [1:0]  dbg_state_o;

   int pass_cnt  = 0;
   int total_cnt = 0;

   // Scoreboards: lane-0 beat addresses and {resp, id} per burst
   logic [31:0] exp_addr_q[$];
   logic [4:0]  exp_r_q[$];

   axi2mem_rd_channel_mb dut (
      .clk_i                 (clk_i),
      .rst_ni                (rst_ni),
      .axi_slave_ar_valid_i  (axi_slave_ar_valid_i),
      .axi_slave_ar_ready_o  (axi_slave_ar_ready_o),
      .axi_slave_ar_addr_i   (axi_slave_ar_addr_i),
      .axi_slave_ar_len_i    (axi_slave_ar_len_i),
      .axi_slave_ar_size_i   (axi_slave_ar_size_i),
      .axi_slave_ar_burst_i  (axi_slave_ar_burst_i),
      .axi_slave_ar_id_i     (axi_slave_ar_id_i),
      .axi_slave_ar_prot_i   (axi_slave_ar_prot_i),
      .axi_slave_ar_region_i (axi_slave_ar_region_i),
      .axi_slave_ar_lock_i   (axi_slave_ar_lock_i),
      .axi_slave_ar_cache_i  (axi_slave_ar_cache_i),
      .axi_slave_ar_qos_i    (axi_slave_ar_qos_i),
      .axi_slave_ar_user_i   (axi_slave_ar_user_i),
      .axi_slave_r_valid_o   (axi_slave_r_valid_o),
      .axi_slave_r_ready_i   (axi_slave_r_ready_i),
      .axi_slave_r_data_o    (axi_slave_r_data_o),
      .axi_slave_r_resp_o    (axi_slave_r_resp_o),
      .axi_slave_r_last_o    (axi_slave_r_last_o),
      .axi_slave_r_id_o      (axi_slave_r_id_o),
      .axi_slave_r_user_o    (axi_slave_r_user_o),
      .trans_req_o           (trans_req_o),
      .trans_gnt_i           (trans_gnt_i),
      .trans_add_o           (trans_add_o),
      .trans_id_o            (trans_id_o),
      .trans_last_o          (trans_last_o),
      .data_dat_i            (data_dat_i),
      .data_last_i           (data_last_i),
      .data_gnt_i            (data_gnt_i),
      .data_req_o            (data_req_o),
      .dbg_state_o           (dbg_state_o)
   );

   // Clock
   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Drive one AR and follow its beats, checking each against exp_addr_q.
   // stall_at: beat index before which grants drop for two partial-grant cycles.
   task automatic issue_burst(input logic [31:0] addr, input logic [7:0] len,
                              input logic [2:0] size, input logic [1:0] burst,
                              input logic [2:0] id, input int stall_at);
      int beat;
      int cyc;
      int stall_done;
      logic accepted;
      logic [31:0] exp_a;
      beat = 0;
      cyc = 0;
      stall_done = 0;
      accepted = 1'b0;
      axi_slave_ar_addr_i  = addr;
      axi_slave_ar_len_i   = len;
      axi_slave_ar_size_i  = size;
      axi_slave_ar_burst_i = burst;
      axi_slave_ar_id_i    = id;
      axi_slave_ar_valid_i = 1'b1;
      trans_gnt_i          = 2'b11;
      while (beat <= int'(len) && cyc < 64) begin
         #2;
         if (trans_gnt_i != 2'b11) begin
            check("stall_req", trans_req_o, 0);
            check("stall_addr_held", trans_add_o[31:0], exp_addr_q[0]);
         end else if (trans_req_o == 2'b11) begin
            if (!accepted) check("ar_ready_accept", axi_slave_ar_ready_o, 1);
            else check("trans_id_run", trans_id_o, {2{6'(id)}});
            exp_a = exp_addr_q.pop_front();
            check("lane0_addr", trans_add_o[31:0], exp_a);
            check("lane1_addr", trans_add_o[63:32], exp_a + 32'd4);
            check("trans_last", trans_last_o, (beat == int'(len)) ? 2'b11 : 2'b00);
            beat++;
         end
         if (axi_slave_ar_valid_i && axi_slave_ar_ready_o) begin
            accepted = 1'b1;
            exp_r_q.push_back({(burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY, id});
         end
         tick();
         if (accepted) axi_slave_ar_valid_i = 1'b0;
         if (beat == stall_at && stall_done < 2) begin
            trans_gnt_i = (stall_done == 0) ? 2'b01 : 2'b10;
            stall_done++;
         end else begin
            trans_gnt_i = 2'b11;
         end
         cyc++;
      end
      check("burst_beats_done", beat, int'(len) + 1);
   endtask

   // Return nbeats of memory data for the oldest outstanding burst
   task automatic return_data(input int nbeats);
      logic [63:0] dat;
      logic [4:0]  exp_r;
      check("r_scoreboard_nonempty", exp_r_q.size() != 0, 1);
      exp_r = (exp_r_q.size() != 0) ? exp_r_q.pop_front() : 5'h0;
      for (int k = 0; k < nbeats; k++) begin
         dat = {$urandom, $urandom};
         data_dat_i  = dat;
         data_last_i = (k == nbeats - 1);
         data_gnt_i  = 1'b1;
         #2;
         check("r_valid", axi_slave_r_valid_o, 1);
         check("r_data", axi_slave_r_data_o, dat);
         check("r_last", axi_slave_r_last_o, (k == nbeats - 1));
         check("r_id", axi_slave_r_id_o, exp_r[2:0]);
         check("r_resp", axi_slave_r_resp_o, exp_r[4:3]);
         check("data_req", data_req_o, 1);
         tick();
      end
      data_gnt_i  = 1'b0;
      data_last_i = 1'b0;
   endtask

   initial begin
      rst_ni                = 1'b0;
      axi_slave_ar_valid_i  = 1'b1;
      axi_slave_ar_addr_i   = 32'h1004;
      axi_slave_ar_len_i    = 8'd0;
      axi_slave_ar_size_i   = 3'd3;
      axi_slave_ar_burst_i  = BURST_INCR;
      axi_slave_ar_id_i     = 3'd0;
      axi_slave_ar_prot_i   = 3'd0;
      axi_slave_ar_region_i = 4'd0;
      axi_slave_ar_lock_i   = 1'b0;
      axi_slave_ar_cache_i  = 4'd0;
      axi_slave_ar_qos_i    = 4'd0;
      axi_slave_ar_user_i   = 6'd0;
      axi_slave_r_ready_i   = 1'b1;
      trans_gnt_i           = 2'b11;
      data_dat_i            = 64'h0;
      data_last_i           = 1'b1;
      data_gnt_i            = 1'b1;

      // Reset with every input that could wake an output held active
      repeat (3) tick();
      #2;
      check("rst_ar_ready", axi_slave_ar_ready_o, 0);
      check("rst_trans_req", trans_req_o, 0);
      check("rst_trans_last", trans_last_o, 0);
      check("rst_trans_add", trans_add_o, 0);
      check("rst_trans_id", trans_id_o, 0);
      check("rst_r_valid", axi_slave_r_valid_o, 0);
      check("rst_r_last", axi_slave_r_last_o, 0);
      check("rst_r_resp", axi_slave_r_resp_o, 0);
      check("rst_data_req", data_req_o, 0);
      tick();
      rst_ni = 1'b1;
      #2;
      check("post_rst_ar_ready", axi_slave_ar_ready_o, 0);
      check("post_rst_trans_req", trans_req_o, 0);
      check("post_rst_r_last", axi_slave_r_last_o, 0);
      axi_slave_ar_valid_i = 1'b0;
      data_gnt_i  = 1'b0;
      data_last_i = 1'b0;
      tick();
      #2;
      check("idle_ar_ready", axi_slave_ar_ready_o, 1);
      check("idle_state", dbg_state_o, ST_IDLE);
      check("idle_r_valid", axi_slave_r_valid_o, 0);
      tick();

      // Single beat
      exp_addr_q.push_back(32'h1000);
      issue_burst(32'h1004, 8'd0, 3'd3, BURST_INCR, 3'd1, -1);
      check("single_state_idle", dbg_state_o, ST_IDLE);
      check("single_next_ar_ready", axi_slave_ar_ready_o, 1);
      return_data(1);

      // INCR with a two-cycle partial-grant stall before beat 2
      exp_addr_q.push_back(32'h100);
      exp_addr_q.push_back(32'h108);
      exp_addr_q.push_back(32'h110);
      exp_addr_q.push_back(32'h118);
      issue_burst(32'h100, 8'd3, 3'd3, BURST_INCR, 3'd2, 2);
      check("incr_state_idle", dbg_state_o, ST_IDLE);
      check("incr_next_ar_ready", axi_slave_ar_ready_o, 1);
      return_data(4);

      // WRAP
      exp_addr_q.push_back(32'h118);
      exp_addr_q.push_back(32'h100);
      exp_addr_q.push_back(32'h108);
      exp_addr_q.push_back(32'h110);
      issue_burst(32'h118, 8'd3, 3'd3, BURST_WRAP, 3'd3, -1);
      return_data(4);

      // FIXED
      repeat (3) exp_addr_q.push_back(32'h40);
      issue_burst(32'h40, 8'd2, 3'd3, BURST_FIXED, 3'd4, -1);
      return_data(3);

      // Narrow INCR
      exp_addr_q.push_back(32'h0);
      exp_addr_q.push_back(32'h0);
      exp_addr_q.push_back(32'h8);
      exp_addr_q.push_back(32'h8);
      issue_burst(32'h0, 8'd3, 3'd2, BURST_INCR, 3'd5, -1);
      return_data(4);

      // Outstanding IDs: fill the ID FIFO, then a 5th AR must wait
      for (int n = 1; n <= 4; n++) begin
         exp_addr_q.push_back(32'h200 + 32'(8 * n));
         issue_burst(32'h200 + 32'(8 * n), 8'd0, 3'd3, BURST_INCR, 3'(n), -1);
      end
      axi_slave_ar_addr_i  = 32'h300;
      axi_slave_ar_len_i   = 8'd0;
      axi_slave_ar_burst_i = BURST_INCR;
      axi_slave_ar_id_i    = 3'd5;
      axi_slave_ar_valid_i = 1'b1;
      for (int c = 0; c < 3; c++) begin
         #2;
         check("full_ar_ready", axi_slave_ar_ready_o, 0);
         check("full_trans_req", trans_req_o, 0);
         tick();
      end
      axi_slave_r_ready_i = 1'b0;
      data_gnt_i  = 1'b1;
      data_last_i = 1'b1;
      data_dat_i  = {$urandom, $urandom};
      for (int c = 0; c < 2; c++) begin
         #2;
         check("hold_r_valid", axi_slave_r_valid_o, 1);
         check("hold_data_req", data_req_o, 0);
         check("hold_r_id", axi_slave_r_id_o, exp_r_q[0][2:0]);
         check("hold_ar_ready", axi_slave_ar_ready_o, 0);
         tick();
      end
      axi_slave_r_ready_i = 1'b1;
      #2;
      check("pop_push_data_req", data_req_o, 1);
      check("pop_push_r_id", axi_slave_r_id_o, exp_r_q[0][2:0]);
      check("pop_push_ar_ready", axi_slave_ar_ready_o, 1);
      check("pop_push_trans_req", trans_req_o, 2'b11);
      check("pop_push_lane0", trans_add_o[31:0], 32'h300);
      void'(exp_r_q.pop_front());
      exp_r_q.push_back({RESP_OKAY, 3'd5});
      tick();
      axi_slave_ar_valid_i = 1'b0;
      data_gnt_i  = 1'b0;
      data_last_i = 1'b0;
      for (int n = 0; n < 4; n++) return_data(1);
      #2;
      check("drained_r_valid", axi_slave_r_valid_o, 0);
      tick();

      // Reserved burst type answers with SLVERR on every beat
      exp_addr_q.push_back(32'h500);
      exp_addr_q.push_back(32'h508);
      issue_burst(32'h500, 8'd1, 3'd3, BURST_RSVD, 3'd6, -1);
      return_data(2);

      // Reset in the middle of a len-7 burst
      axi_slave_ar_addr_i  = 32'h600;
      axi_slave_ar_len_i   = 8'd7;
      axi_slave_ar_size_i  = 3'd3;
      axi_slave_ar_burst_i = BURST_INCR;
      axi_slave_ar_id_i    = 3'd7;
      axi_slave_ar_valid_i = 1'b1;
      #2;
      check("mid_beat0_lane0", trans_add_o[31:0], 32'h600);
      tick();
      axi_slave_ar_valid_i = 1'b0;
      #2;
      check("mid_beat1_lane0", trans_add_o[31:0], 32'h608);
      check("mid_beat1_req", trans_req_o, 2'b11);
      tick();
      rst_ni     = 1'b0;
      data_gnt_i = 1'b1;
      #2;
      check("mid_rst_req", trans_req_o, 0);
      tick();
      rst_ni = 1'b1;
      exp_r_q.delete();
      #2;
      check("abort_req", trans_req_o, 0);
      check("abort_r_valid", axi_slave_r_valid_o, 0);
      tick();
      #2;
      check("abort_req_later", trans_req_o, 0);
      check("abort_fifo_empty", axi_slave_r_valid_o, 0);
      check("abort_state_idle", dbg_state_o, ST_IDLE);
      check("abort_ar_ready", axi_slave_ar_ready_o, 1);
      data_gnt_i = 1'b0;
      tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
